// File: rtl/register_file.sv
// Y86 architectural register file: two write ports from write-back, two
// registered write-first read ports for decode, sticky bad-ID flag, write counter.
module register_file #(
    parameter int          WIDTH = 32,
    parameter int          NREGS = 8,
    parameter logic [3:0]  RNONE = 4'hF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             regWrite1,
    input  logic [3:0]       regReg1,
    input  logic [WIDTH-1:0] regValue1,
    input  logic             regWrite2,
    input  logic [3:0]       regReg2,
    input  logic [WIDTH-1:0] regValue2,
    input  logic [3:0]       srcA,
    input  logic [3:0]       srcB,
    output logic [WIDTH-1:0] valA,
    output logic [WIDTH-1:0] valB,
    output logic             badReg,
    output logic [15:0]      wrCount
);

    localparam int         IW       = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [3:0] NREGS_ID = 4'(NREGS);

    // IDs between the last real register and RNONE are architecturally illegal
    function automatic logic is_bad_id(input logic [3:0] id);
        return (id >= NREGS_ID) && (id != RNONE);
    endfunction

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [WIDTH-1:0] val_a_q, val_a_d;
    logic [WIDTH-1:0] val_b_q, val_b_d;
    logic             bad_q, bad_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             wr1_s, wr2_s;
    logic [15:0]      inc_s;

    // Next-state: array update (port 2 last so it wins), forwarded reads, flag, counter
    always_comb begin
        wr1_s = regWrite1 && (regReg1 < NREGS_ID);
        wr2_s = regWrite2 && (regReg2 < NREGS_ID);

        regs_d = regs_q;
        if (wr1_s) begin
            regs_d[regReg1[IW-1:0]] = regValue1;
        end else begin
            regs_d = regs_d;
        end
        if (wr2_s) begin
            regs_d[regReg2[IW-1:0]] = regValue2;
        end else begin
            regs_d = regs_d;
        end

        // Reading regs_d gives write-first semantics with port-2 priority for free
        if (srcA < NREGS_ID) begin
            val_a_d = regs_d[srcA[IW-1:0]];
        end else begin
            val_a_d = {WIDTH{1'b0}};
        end
        if (srcB < NREGS_ID) begin
            val_b_d = regs_d[srcB[IW-1:0]];
        end else begin
            val_b_d = {WIDTH{1'b0}};
        end

        bad_d = bad_q
              | (regWrite1 & is_bad_id(regReg1))
              | (regWrite2 & is_bad_id(regReg2))
              | is_bad_id(srcA)
              | is_bad_id(srcB);

        if (wr1_s && wr2_s && (regReg1 == regReg2)) begin
            inc_s = 16'd1;
        end else begin
            inc_s = {15'd0, wr1_s} + {15'd0, wr2_s};
        end
        cnt_d = cnt_q + inc_s;
    end

    // State and output registers with immediate clear on reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {WIDTH{1'b0}};
            end
            val_a_q <= {WIDTH{1'b0}};
            val_b_q <= {WIDTH{1'b0}};
            bad_q   <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            regs_q  <= regs_d;
            val_a_q <= val_a_d;
            val_b_q <= val_b_d;
            bad_q   <= bad_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valA    = val_a_q;
    assign valB    = val_b_q;
    assign badReg  = bad_q;
    assign wrCount = cnt_q;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: hand-computed expectations for reset, writes,
// forwarding, dual-write resolution, bad IDs and counter wrap.
module tb_register_file;

    logic        clock = 1'b0;
    logic        reset;
    logic        regWrite1, regWrite2;
    logic [3:0]  regReg1, regReg2, srcA, srcB;
    logic [31:0] regValue1, regValue2;
    logic [31:0] valA, valB;
    logic        badReg;
    logic [15:0] wrCount;

    int total_cnt = 0;
    int bad_cnt   = 0;

    register_file dut (
        .clock     (clock),
        .reset     (reset),
        .regWrite1 (regWrite1),
        .regReg1   (regReg1),
        .regValue1 (regValue1),
        .regWrite2 (regWrite2),
        .regReg2   (regReg2),
        .regValue2 (regValue2),
        .srcA      (srcA),
        .srcB      (srcB),
        .valA      (valA),
        .valB      (valB),
        .badReg    (badReg),
        .wrCount   (wrCount)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle so outputs are sampled away from it
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_writes();
        regWrite1 = 1'b0;
        regWrite2 = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        regWrite1 = 1'b0; regReg1 = 4'd0; regValue1 = 32'd0;
        regWrite2 = 1'b0; regReg2 = 4'd0; regValue2 = 32'd0;
        srcA = 4'd0; srcB = 4'd0;

        step(); step();
        check_val("rst_valA", valA, 32'd0);
        check_val("rst_valB", valB, 32'd0);
        check_val("rst_cnt", {16'd0, wrCount}, 32'd0);
        check_val("rst_bad", {31'd0, badReg}, 32'd0);
        reset = 1'b0;

        // Basic write/read, forwarded on the write edge then from the array
        regWrite1 = 1'b1; regReg1 = 4'd2; regValue1 = 32'hDEADBEEF; srcA = 4'd2;
        step();
        check_val("wr_fwd_valA", valA, 32'hDEADBEEF);
        check_val("wr_cnt1", {16'd0, wrCount}, 32'd1);
        idle_writes();
        step();
        check_val("rd_valA", valA, 32'hDEADBEEF);

        // Same-edge forwarding on port 2
        regWrite2 = 1'b1; regReg2 = 4'd5; regValue2 = 32'h55; srcB = 4'd5;
        step();
        check_val("fwd_valB", valB, 32'h55);
        check_val("fwd_cnt", {16'd0, wrCount}, 32'd2);
        idle_writes();

        // Dual-write conflict: port 2 wins, counted once
        regWrite1 = 1'b1; regReg1 = 4'd4; regValue1 = 32'h100;
        regWrite2 = 1'b1; regReg2 = 4'd4; regValue2 = 32'h200; srcA = 4'd4;
        step();
        check_val("conf_fwd", valA, 32'h200);
        check_val("conf_cnt", {16'd0, wrCount}, 32'd3);
        idle_writes();
        step();
        check_val("conf_arr", valA, 32'h200);

        // Dual-write distinct registers
        regWrite1 = 1'b1; regReg1 = 4'd6; regValue1 = 32'h10;
        regWrite2 = 1'b1; regReg2 = 4'd0; regValue2 = 32'h20; srcA = 4'd6; srcB = 4'd0;
        step();
        check_val("dist_valA", valA, 32'h10);
        check_val("dist_valB", valB, 32'h20);
        check_val("dist_cnt", {16'd0, wrCount}, 32'd5);
        idle_writes();

        // Write to RNONE and read of RNONE: no effect, no flag
        regWrite1 = 1'b1; regReg1 = 4'hF; regValue1 = 32'h99; srcA = 4'hF; srcB = 4'd2;
        step();
        check_val("none_valA", valA, 32'd0);
        check_val("none_valB", valB, 32'hDEADBEEF);
        check_val("none_cnt", {16'd0, wrCount}, 32'd5);
        check_val("none_bad", {31'd0, badReg}, 32'd0);
        idle_writes();
        srcA = 4'd6; srcB = 4'd0;
        step();
        check_val("none_keepA", valA, 32'h10);
        check_val("none_keepB", valB, 32'h20);

        // Illegal write ID sets the sticky flag without counting
        regWrite1 = 1'b1; regReg1 = 4'h9; regValue1 = 32'h77;
        step();
        check_val("illw_bad", {31'd0, badReg}, 32'd1);
        check_val("illw_cnt", {16'd0, wrCount}, 32'd5);
        idle_writes();

        // Illegal read ID returns zero, flag stays set
        srcA = 4'hA;
        step();
        check_val("illr_valA", valA, 32'd0);
        check_val("illr_bad", {31'd0, badReg}, 32'd1);
        srcA = 4'd1;
        step();
        check_val("sticky_bad", {31'd0, badReg}, 32'd1);

        // Mid-run reset clears outputs immediately and empties the array
        regWrite1 = 1'b1; regReg1 = 4'd3; regValue1 = 32'h1234; srcA = 4'd3; srcB = 4'd3;
        step();
        check_val("pre_rst_valA", valA, 32'h1234);
        idle_writes();
        reset = 1'b1;
        #1;
        check_val("async_valA", valA, 32'd0);
        check_val("async_valB", valB, 32'd0);
        check_val("async_cnt", {16'd0, wrCount}, 32'd0);
        check_val("async_bad", {31'd0, badReg}, 32'd0);
        regWrite1 = 1'b1; regReg1 = 4'd3; regValue1 = 32'hFFFF;
        step();
        check_val("held_valA", valA, 32'd0);
        check_val("held_cnt", {16'd0, wrCount}, 32'd0);
        idle_writes();
        reset = 1'b0;
        srcA = 4'd3;
        step();
        check_val("post_rst_valA", valA, 32'd0);

        // Counter wrap: 32767 dual writes + 1 single reach 0xFFFF, next write wraps
        regWrite1 = 1'b1; regReg1 = 4'd1; regValue1 = 32'hA;
        regWrite2 = 1'b1; regReg2 = 4'd7; regValue2 = 32'hB;
        for (int i = 0; i < 32767; i++) begin
            step();
        end
        check_val("cnt_fffe", {16'd0, wrCount}, 32'h0000FFFE);
        regWrite2 = 1'b0;
        step();
        check_val("cnt_ffff", {16'd0, wrCount}, 32'h0000FFFF);
        step();
        check_val("cnt_wrap", {16'd0, wrCount}, 32'd0);
        idle_writes();
        srcA = 4'd1; srcB = 4'd7;
        step();
        check_val("wrap_valA", valA, 32'hA);
        check_val("wrap_valB", valB, 32'hB);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
